// File: rtl/hack_pkg.sv
// Shared definitions for the 4-way word demultiplexer slice.
//   HACK_WORD : default data width
//   CH_A..CH_D: channel index constants for sel
//   EMPTY/FULL: one-entry slot state encoding
//   onehot4   : 2-bit index to 4-bit one-hot decode
package hack_pkg;

  localparam int unsigned HACK_WORD = 16;

  localparam logic [1:0] CH_A = 2'b00;
  localparam logic [1:0] CH_B = 2'b01;
  localparam logic [1:0] CH_C = 2'b10;
  localparam logic [1:0] CH_D = 2'b11;

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  function automatic logic [3:0] onehot4(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/dmux4way16_buf_if.sv
// Bus bundle for dmux4way16_buf.
//   in/sel/in_valid/in_ready        : input word handshake
//   out_k/valid_k/ready_k (k=a..d)  : per-channel output handshakes
// Modports: master = producer/consumer side, slave = demux block.
interface dmux4way16_buf_if
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = HACK_WORD
);

  logic [WIDTH-1:0] in;
  logic [1:0]       sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
  logic             valid_a, valid_b, valid_c, valid_d;
  logic             ready_a, ready_b, ready_c, ready_d;

  modport master (
    output in, sel, in_valid,
    input  in_ready,
    input  out_a, out_b, out_c, out_d,
    input  valid_a, valid_b, valid_c, valid_d,
    output ready_a, ready_b, ready_c, ready_d
  );

  modport slave (
    input  in, sel, in_valid,
    output in_ready,
    output out_a, out_b, out_c, out_d,
    output valid_a, valid_b, valid_c, valid_d,
    input  ready_a, ready_b, ready_c, ready_d
  );

endinterface

// File: rtl/dmux4way16_buf_slot.sv
// dmux_slot: one-entry output register with valid/ready handshake.
//   clk, reset : clock, synchronous active-high reset
//   load, din  : write din into the slot this cycle
//   ready      : consumer takes the held word this cycle
//   valid,dout : slot holds an undelivered word / held data
// The parent only asserts load when the slot is EMPTY or draining this
// cycle, so load takes priority and a drain+load keeps the slot FULL.
module dmux_slot
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = HACK_WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  logic state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      dout  <= '0;
    end else if (load) begin
      state <= FULL;
      dout  <= din;
    end else if (state == FULL && ready) begin
      state <= EMPTY;
    end
  end

  assign valid = (state == FULL);

endmodule

// File: rtl/dmux4way16_buf.sv
// dmux4way16_buf: routes one input word per transfer to channel a/b/c/d
// selected by sel, each channel buffered in a one-entry register.
//   clk, reset : clock, synchronous active-high reset
//   bus        : dmux4way16_buf_if.slave (input handshake + 4 channels)
// Optional (macro DMUX4WAY16_BUF_COUNT_EN):
//   cnt_sel    : selects which per-channel drain counter to read
//   cnt_out    : combinational read of that 16-bit wrapping counter
// in_ready looks only at the currently selected channel, so a full
// channel stalls only words addressed to it.
module dmux4way16_buf
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = HACK_WORD
) (
  input  logic              clk,
  input  logic              reset,
  dmux4way16_buf_if.slave   bus
`ifdef DMUX4WAY16_BUF_COUNT_EN
  ,
  input  logic [1:0]        cnt_sel,
  output logic [15:0]       cnt_out
`endif
);

  logic [3:0]       rdy;
  logic [3:0]       vld;
  logic [3:0]       load;
  logic             in_ready;
  logic [WIDTH-1:0] dout [4];

  assign rdy      = {bus.ready_d, bus.ready_c, bus.ready_b, bus.ready_a};
  assign in_ready = ~vld[bus.sel] | rdy[bus.sel];
  assign load     = onehot4(bus.sel) & {4{bus.in_valid & in_ready}};

  for (genvar k = 0; k < 4; k++) begin : g_slot
    dmux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (load[k]),
      .din   (bus.in),
      .ready (rdy[k]),
      .valid (vld[k]),
      .dout  (dout[k])
    );
  end

  assign bus.in_ready = in_ready;
  assign bus.out_a    = dout[CH_A];
  assign bus.out_b    = dout[CH_B];
  assign bus.out_c    = dout[CH_C];
  assign bus.out_d    = dout[CH_D];
  assign bus.valid_a  = vld[CH_A];
  assign bus.valid_b  = vld[CH_B];
  assign bus.valid_c  = vld[CH_C];
  assign bus.valid_d  = vld[CH_D];

`ifdef DMUX4WAY16_BUF_COUNT_EN
  logic [3:0]  drain;
  logic [15:0] cnt [4];

  assign drain = vld & rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < 4; k++)
        if (drain[k]) cnt[k] <= cnt[k] + 16'd1;
    end
  end

  assign cnt_out = cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_dmux4way16_buf.sv
module tb_dmux4way16_buf;
  import hack_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  dmux4way16_buf_if #(.WIDTH(16)) bus ();

`ifdef DMUX4WAY16_BUF_COUNT_EN
  logic [1:0]  cnt_sel;
  logic [15:0] cnt_out;
  logic [15:0] mc [4];
`endif

  dmux4way16_buf #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DMUX4WAY16_BUF_COUNT_EN
    ,
    .cnt_sel (cnt_sel),
    .cnt_out (cnt_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per channel, whether an undelivered word is held and its value.
  logic        mv [4];
  logic [15:0] md [4];

  function automatic logic [15:0] get_out(input int k);
    case (k)
      0: return bus.out_a;
      1: return bus.out_b;
      2: return bus.out_c;
      default: return bus.out_d;
    endcase
  endfunction

  function automatic logic get_valid(input int k);
    case (k)
      0: return bus.valid_a;
      1: return bus.valid_b;
      2: return bus.valid_c;
      default: return bus.valid_d;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s valid_%0d", tag, k), {15'b0, get_valid(k)}, {15'b0, mv[k]});
      chk($sformatf("%s out_%0d", tag, k), get_out(k), md[k]);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 1'b0;
      md[k] = 16'h0000;
`ifdef DMUX4WAY16_BUF_COUNT_EN
      mc[k] = 16'h0000;
`endif
    end
  endtask

  task automatic drive(input logic [15:0] din, input logic [1:0] s,
                       input logic iv, input logic [3:0] rdy);
    bus.in       = din;
    bus.sel      = s;
    bus.in_valid = iv;
    bus.ready_a  = rdy[0];
    bus.ready_b  = rdy[1];
    bus.ready_c  = rdy[2];
    bus.ready_d  = rdy[3];
  endtask

  // One clock cycle: drive, check in_ready, clock, advance model, check outputs.
  task automatic step(input logic [15:0] din, input logic [1:0] s,
                      input logic iv, input logic [3:0] rdy);
    logic exp_ir;
    logic dr [4];
    drive(din, s, iv, rdy);
    #1;
    exp_ir = !mv[s] || rdy[s];
    chk("in_ready", {15'b0, bus.in_ready}, {15'b0, exp_ir});
    for (int k = 0; k < 4; k++) dr[k] = mv[k] && rdy[k];
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
`ifdef DMUX4WAY16_BUF_COUNT_EN
      if (dr[k]) mc[k] = mc[k] + 16'd1;
`endif
      if (iv && exp_ir && int'(s) == k) begin
        mv[k] = 1'b1;
        md[k] = din;
      end else if (dr[k]) begin
        mv[k] = 1'b0;
      end
    end
    #1;
    check_all("step");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    check_all("reset");
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    model_clear();
    drive(16'h0000, CH_A, 1'b0, 4'b0000);
`ifdef DMUX4WAY16_BUF_COUNT_EN
    cnt_sel = CH_A;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset");
    for (int s = 0; s < 4; s++) begin
      bus.sel = s[1:0];
      #1;
      chk($sformatf("reset in_ready sel%0d", s), {15'b0, bus.in_ready}, 16'h0001);
    end

    // Route and drain each channel on consecutive cycles.
    step(16'h5500, CH_A, 1'b1, 4'b1111);
    chk("route out_a", bus.out_a, 16'h5500);
    step(16'hAA00, CH_B, 1'b1, 4'b1111);
    chk("route out_b", bus.out_b, 16'hAA00);
    step(16'h0055, CH_C, 1'b1, 4'b1111);
    chk("route out_c", bus.out_c, 16'h0055);
    step(16'h00AA, CH_D, 1'b1, 4'b1111);
    chk("route out_d", bus.out_d, 16'h00AA);
    chk("route valid_c drained", {15'b0, bus.valid_c}, 16'h0000);
    step(16'h0000, CH_A, 1'b0, 4'b1111);

    // Backpressure on b; c still accepted meanwhile.
    step(16'h1234, CH_B, 1'b1, 4'b1101);
    drive(16'h5678, CH_B, 1'b1, 4'b1101);
    #1;
    chk("bp in_ready b full", {15'b0, bus.in_ready}, 16'h0000);
    step(16'h5678, CH_B, 1'b1, 4'b1101);
    chk("bp out_b held", bus.out_b, 16'h1234);
    step(16'h0C0C, CH_C, 1'b1, 4'b1101);
    chk("bp out_c", bus.out_c, 16'h0C0C);
    step(16'h5678, CH_B, 1'b1, 4'b1111);
    chk("bp out_b next", bus.out_b, 16'h5678);
    chk("bp valid_b", {15'b0, bus.valid_b}, 16'h0001);
    step(16'h0000, CH_A, 1'b0, 4'b1111);

    // Simultaneous drain and accept on d.
    step(16'hAAAA, CH_D, 1'b1, 4'b0000);
    step(16'h5555, CH_D, 1'b1, 4'b1000);
    chk("d no bubble valid", {15'b0, bus.valid_d}, 16'h0001);
    chk("d no bubble out", bus.out_d, 16'h5555);

    // Reset with a and c full.
    step(16'h1111, CH_A, 1'b1, 4'b0000);
    step(16'h3333, CH_C, 1'b1, 4'b0000);
    drive(16'h9999, CH_B, 1'b1, 4'b0000);
    do_reset();
    chk("midreset out_a", bus.out_a, 16'h0000);
    step(16'h7777, CH_C, 1'b1, 4'b0000);
    chk("after reset out_c", bus.out_c, 16'h7777);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      step(16'($urandom), 2'($urandom), 1'($urandom), 4'($urandom));

`ifdef DMUX4WAY16_BUF_COUNT_EN
    do_reset();
    step(16'h0001, CH_A, 1'b1, 4'b0001);
    step(16'h0002, CH_A, 1'b1, 4'b0001);
    step(16'h0003, CH_A, 1'b1, 4'b0001);
    step(16'h0000, CH_A, 1'b0, 4'b0001);
    step(16'h0004, CH_D, 1'b1, 4'b0000);
    step(16'h0000, CH_A, 1'b0, 4'b1000);
    for (int s = 0; s < 4; s++) begin
      cnt_sel = s[1:0];
      #1;
      chk($sformatf("cnt model sel%0d", s), cnt_out, mc[s]);
    end
    cnt_sel = CH_A; #1; chk("cnt a", cnt_out, 16'd3);
    cnt_sel = CH_B; #1; chk("cnt b", cnt_out, 16'd0);
    cnt_sel = CH_D; #1; chk("cnt d", cnt_out, 16'd1);

    // Wrap: first edge loads a, each following edge drains and reloads it.
    do_reset();
    cnt_sel = CH_A;
    drive(16'hBEEF, CH_A, 1'b1, 4'b0001);
    repeat (65536) @(posedge clk);
    #1;
    chk("cnt preload ffff", cnt_out, 16'hFFFF);
    @(posedge clk);
    #1;
    chk("cnt wrap", cnt_out, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmux4way16_buf.md
Name: dmux4way16_buf

Overview:
- Write-side counterpart of the 4-way 16-bit word selector.
- Accepts one 16-bit word per transfer on a valid/ready input port and routes it to one of four output channels (a, b, c, d) chosen by sel.
- Each channel has a one-entry output register with its own valid/ready handshake.
- Sits in front of four independent consumers, e.g. per-bank write ports of a RAM4 or per-device I/O latches.

Parameters:
- WIDTH, 16, data width of the input word and of each channel.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- in  input  WIDTH  input word
- sel  input  2  destination channel: 00=a, 01=b, 10=c, 11=d
- in_valid  input  1  in and sel are valid this cycle
- in_ready  output  1  block accepts the word this cycle
- out_a, out_b, out_c, out_d  output  WIDTH  channel data registers
- valid_a, valid_b, valid_c, valid_d  output  1  channel register holds an undelivered word
- ready_a, ready_b, ready_c, ready_d  input  1  consumer takes the channel word this cycle

Behaviour:
- Reset (clk edge with reset=1): all valid_k=0, all out_k=0. Reset overrides every other event, including one mid-transfer; words in flight are discarded.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Channel k drains when valid_k & ready_k.
- in_ready is combinational: in_ready = ~valid_s | ready_s, where s = sel.
  - It depends only on the selected channel.
  - A full channel blocks input only for words addressed to it.
- Per-channel state: 2 states, EMPTY (valid_k=0) and FULL (valid_k=1).
  - EMPTY + accept for k -> FULL; out_k <= in.
  - FULL + drain, no accept for k -> EMPTY; out_k holds its value.
  - FULL + drain + accept for k in the same cycle -> stays FULL; out_k <= new in. No bubble.
  - FULL + no drain -> FULL, out_k stable. in_ready=0 when sel=k.
- Latency: the word appears on out_k with valid_k=1 on the cycle after acceptance. There is no combinational path from in to out_k.
- Unselected channels are unaffected by an input transfer and drain independently in the same cycle.
- out_k keeps its last value after draining; consumers must qualify it with valid_k.
- ready_k asserted while valid_k=0 has no effect.
- sel and in may change freely while in_valid=0.
- Changing sel while in_valid=1 and in_ready=0 is legal. The block evaluates in_ready against the new sel with no memory of the old one.
- Width rule: data is copied unmodified; no arithmetic.

Optional Feature:
- Macro: DMUX4WAY16_BUF_COUNT_EN.
- Defined:
  - Adds input cnt_sel[1:0] and output cnt_out[15:0].
  - Four 16-bit counters, one per channel, increment on each drain of their channel.
  - Counters wrap 16'hFFFF -> 16'h0000 and reset to 0.
  - cnt_out = counter[cnt_sel], combinational.
- Not defined: the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package hack_pkg holds:
  - channel index constants CH_A=2'b00, CH_B=2'b01, CH_C=2'b10, CH_D=2'b11;
  - the default data width constant HACK_WORD=16.
- Sub-module dmux_slot: a one-entry register with load/data/ready/valid, instantiated four times. The top level holds only the sel decode, the in_ready mux and the optional counters.

Test Plan:
- Reset -> all valid_k=0 and out_k=16'h0000; in_ready=1 for every sel.
- Route and drain each channel:
  - Setup: all ready_k=1. Send a=16'b0101010100000000 (sel=00), b=16'b1010101000000000 (01), c=16'b0000000001010101 (10), d=16'b0000000010101010 (11) on consecutive cycles.
  - Expected: each appears on its out_k with valid_k=1 exactly one cycle after acceptance, and no other channel's valid rises.
- Backpressure:
  - Setup: ready_b=0. Send 16'h1234 to b, then 16'h5678 to b.
  - Expected: first accepted, second sees in_ready=0. A word to c (sel=10) in the same period is accepted. After ready_b=1, b drains 16'h1234 and then accepts 16'h5678.
- Simultaneous drain and accept on d:
  - Setup: FULL with 16'hAAAA, ready_d=1, new word 16'h5555.
  - Expected: valid_d stays 1 and out_d=16'h5555 next cycle, with no empty cycle.
- Reset mid-operation:
  - Setup: channels a and c FULL, reset=1 for one cycle.
  - Expected: all valid=0 and out=0, then normal acceptance resumes the following cycle.
- With DMUX4WAY16_BUF_COUNT_EN:
  - Stimulus: drain channel a 3 times and channel d once.
  - Expected: cnt_out reads 3 (cnt_sel=00), 0 (01), 1 (11). Preloading 16'hFFFF drains and then one more drain -> 0.
